// File: rtl/memgame_pkg.sv
// memgame_pkg: shared types and constants for the memory-game blocks.
// Holds the game state enumeration, the 10-bit LFSR tap positions with the
// matching next-value helper, and default sizing for the sequencer.
package memgame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    PLAY = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  localparam int LFSR_W    = 10;
  // Taps 10 and 7 (bit indices 9 and 6) give a maximal-length 1023 sequence.
  localparam int TAP_HI    = 9;
  localparam int TAP_LO    = 6;

  localparam int WIDTH_DEF = 10;
  localparam int SLOTS_DEF = 10;
  localparam int GOAL_DEF  = 5;

  function automatic logic [LFSR_W-1:0] lfsr10_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
  endfunction

endpackage

// File: rtl/number_seq_if.sv
// number_seq_if: game-control and store-write bundle around number_seq.
//   start, key   : one-cycle pulses from the player side
//   exist        : store reports the current switches match a stored entry
//   wn, d, we    : store write index / data / enable
//   busy, playing, score, win, lose : game status
// Modport master is the sequencer; modport slave is the surrounding system.
interface number_seq_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             key;
  logic             exist;
  logic [3:0]       wn;
  logic [WIDTH-1:0] d;
  logic             we;
  logic             busy;
  logic             playing;
  logic [3:0]       score;
  logic             win;
  logic             lose;

  modport master (
    input  start, key, exist,
    output wn, d, we, busy, playing, score, win, lose
  );

  modport slave (
    output start, key, exist,
    input  wn, d, we, busy, playing, score, win, lose
  );
endinterface

// File: rtl/number_seq_lfsr10.sv
// lfsr10: 10-bit Fibonacci LFSR with synchronous load and step enable.
//   clk   : clock
//   load  : load SEED on the next edge (has priority over step)
//   step  : advance one position on the next edge
//   value : current LFSR contents, never zero when SEED is nonzero
module lfsr10 import memgame_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsr10_next(value);
    end
  end

endmodule

// File: rtl/number_seq.sv
// number_seq: memory-game sequencer upstream of the number store.
// On start it writes SLOTS pseudo-random nonzero patterns into the store, then
// judges one guess per key pulse until GOAL hits (win) or a miss (lose).
//   clk  : clock
//   clrn : synchronous active-low reset
//   bus  : number_seq_if.master (start/key/exist in; wn/d/we and status out)
// Optional build macro NUMBER_SEQ_RESEED_EN: when defined the LFSR also runs
// while IDLE/WIN/LOSE so game content depends on start timing; when undefined
// the LFSR only advances on store writes and games continue one sequence.
module number_seq import memgame_pkg::*; #(
  parameter int                SLOTS = SLOTS_DEF,
  parameter int                WIDTH = WIDTH_DEF,
  parameter logic [LFSR_W-1:0] SEED  = 10'h001,
  parameter int                GOAL  = GOAL_DEF
) (
  input logic           clk,
  input logic           clrn,
  number_seq_if.master  bus
);

  state_t            state;
  logic [3:0]        slot;
  logic [3:0]        score;
  logic [LFSR_W-1:0] lfsr_val;
  logic              lfsr_step;

  lfsr10 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .load  (!clrn),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // The LFSR advances once per store write; the start edge itself never
  // steps it, so the first write of a game uses the value held at start.
  always_comb begin
    lfsr_step = 1'b0;
    if (state == FILL) begin
      lfsr_step = 1'b1;
    end
`ifdef NUMBER_SEQ_RESEED_EN
    else if ((state == IDLE || state == WIN || state == LOSE) && !bus.start) begin
      lfsr_step = 1'b1;
    end
`endif
  end

  assign bus.score = score;

  // Status flags are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= IDLE;
      slot        <= 4'd0;
      score       <= 4'd0;
      bus.we      <= 1'b0;
      bus.wn      <= 4'd0;
      bus.d       <= '0;
      bus.busy    <= 1'b0;
      bus.playing <= 1'b0;
      bus.win     <= 1'b0;
      bus.lose    <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FILL;
            slot     <= 4'd0;
            score    <= 4'd0;
            bus.busy <= 1'b1;
          end
        end
        FILL: begin
          bus.we <= 1'b1;
          bus.wn <= slot;
          bus.d  <= WIDTH'(lfsr_val);
          slot   <= slot + 4'd1;
          if (slot == 4'(SLOTS - 1)) begin
            state       <= PLAY;
            bus.busy    <= 1'b0;
            bus.playing <= 1'b1;
          end
        end
        PLAY: begin
          // start is deliberately not looked at here: a guess in flight wins.
          if (bus.key) begin
            if (bus.exist) begin
              score <= score + 4'd1;
              if (score == 4'(GOAL - 1)) begin
                state       <= WIN;
                bus.playing <= 1'b0;
                bus.win     <= 1'b1;
              end
            end else begin
              state       <= LOSE;
              bus.playing <= 1'b0;
              bus.lose    <= 1'b1;
            end
          end
        end
        WIN, LOSE: begin
          if (bus.start) begin
            state    <= FILL;
            slot     <= 4'd0;
            score    <= 4'd0;
            bus.busy <= 1'b1;
            bus.win  <= 1'b0;
            bus.lose <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_number_seq.sv
module tb_number_seq;
  localparam int          SLOTS = 10;
  localparam int          GOAL  = 5;
  localparam logic [9:0]  SEED  = 10'h001;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  number_seq_if #(.WIDTH(10)) bus();

  number_seq #(
    .SLOTS (SLOTS),
    .WIDTH (10),
    .SEED  (SEED),
    .GOAL  (GOAL)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Game model: phase 0 idle, 1 fill, 2 play, 3 win, 4 lose.
  int m_lfsr;
  int m_score;
  int m_phase;

  int first_tbl [SLOTS] = '{'h001, 'h002, 'h004, 'h008, 'h010,
                            'h020, 'h040, 'h081, 'h102, 'h204};

  function automatic int lfsr_next(input int x);
    return ((x << 1) & 'h3FF) | (((x >> 9) ^ (x >> 6)) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
`ifdef NUMBER_SEQ_RESEED_EN
    if ((m_phase == 0 || m_phase == 3 || m_phase == 4) && !bus.start)
      m_lfsr = lfsr_next(m_lfsr);
`endif
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".busy"},    bus.busy,    32'(m_phase == 1));
    chk({tag, ".playing"}, bus.playing, 32'(m_phase == 2));
    chk({tag, ".win"},     bus.win,     32'(m_phase == 3));
    chk({tag, ".lose"},    bus.lose,    32'(m_phase == 4));
    chk({tag, ".score"},   bus.score,   m_score);
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.key = 1'b0; bus.exist = 1'b0;
    clrn = 1'b0;
    tick(); tick();
    m_phase = 0; m_score = 0; m_lfsr = SEED;
    chk("reset.we", bus.we, 0);
    chk("reset.wn", bus.wn, 0);
    chk("reset.d",  bus.d,  0);
    chk_status("reset");
    clrn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.exist = 1'($urandom_range(0, 1));
      tick();
    end
    bus.exist = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
      m_phase = 1; m_score = 0;
    end
    chk_status("start");
  endtask

  // Expect SLOTS back-to-back writes; start/key are pulsed during write
  // 'noisy' and must be ignored. first_d >= 0 pins the slot-0 data value.
  task automatic run_fill(input int noisy, input int first_d, input bit use_tbl);
    for (int i = 0; i < SLOTS; i++) begin
      bus.start = (i == noisy);
      bus.key   = (i == noisy);
      tick();
      bus.start = 1'b0; bus.key = 1'b0;
      chk("fill.we", bus.we, 1);
      chk("fill.wn", bus.wn, i);
      chk("fill.d",  bus.d,  m_lfsr);
      if (i == 0 && first_d >= 0) chk("fill.d0", bus.d, first_d);
      if (use_tbl) chk("fill.tbl", bus.d, first_tbl[i]);
      m_lfsr = lfsr_next(m_lfsr);
      if (i == SLOTS - 1) m_phase = 2;
      chk_status("fill");
    end
    tick();
    chk("fill.we_off", bus.we, 0);
    chk_status("fill_done");
  endtask

  task automatic guess(input bit ex, input bit st);
    bus.key = 1'b1; bus.exist = ex; bus.start = st;
    tick();
    bus.key = 1'b0; bus.exist = 1'b0; bus.start = 1'b0;
    case (m_phase)
      2: begin
        if (ex) begin
          m_score++;
          if (m_score == GOAL) m_phase = 3;
        end else begin
          m_phase = 4;
        end
      end
      0, 3, 4: if (st) begin m_phase = 1; m_score = 0; end
      default: ;
    endcase
    chk_status("guess");
  endtask

  initial begin
    bit tbl_on;
    int d0;
`ifdef NUMBER_SEQ_RESEED_EN
    tbl_on = 1'b0;
`else
    tbl_on = 1'b1;
`endif
    m_lfsr = SEED; m_score = 0; m_phase = 0;

    do_reset();

    // key in IDLE changes nothing
    guess(1'b1, 1'b0);
    chk("idle_key.we", bus.we, 0);

    // first game: fill with a stray start/key mid-fill, then lose path
    do_start();
    run_fill(4, -1, tbl_on);
    guess(1'b1, 1'b0);
    guess(1'b0, 1'b0);
    chk("lose.score", bus.score, 1);
    guess(1'b1, 1'b0);
    idle(2);

    // restart from LOSE: lfsr continues from where the first fill stopped
    d0 = tbl_on ? 'h009 : -1;
    do_start();
    run_fill(-1, d0, 1'b0);

    // win path with random gaps between hits
    for (int k = 0; k < GOAL; k++) begin
      idle($urandom_range(0, 2));
      guess(1'b1, 1'b0);
    end
    chk("win.flag", bus.win, 1);
    guess(1'b1, 1'b0);
    chk("win.score_cap", bus.score, GOAL);
    idle(2);

    // start+key together in WIN: start wins
    guess(1'b1, 1'b1);
    run_fill(-1, -1, 1'b0);

    // start+key together in PLAY: key processed, start dropped
    guess(1'b1, 1'b1);
    guess(1'b0, 1'b0);

    // randomized games
    for (int g = 0; g < 6; g++) begin
      do_start();
      run_fill(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, SLOTS - 1)) : -1, -1, 1'b0);
      for (int t = 0; t < 30 && m_phase == 2; t++) begin
        idle($urandom_range(0, 2));
        guess($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0);
      end
      if (m_phase == 2) guess(1'b0, 1'b0);
      idle($urandom_range(0, 3));
    end

    // reset asserted at the 4th write of a fill
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstfill.we", bus.we, 1);
      chk("rstfill.wn", bus.wn, i);
      m_lfsr = lfsr_next(m_lfsr);
    end
    clrn = 1'b0;
    tick();
    m_phase = 0; m_score = 0; m_lfsr = SEED;
    chk("rstfill.we_off", bus.we, 0);
    chk_status("rstfill");
    clrn = 1'b1;
    do_start();
    run_fill(-1, 'h001, 1'b0);
    guess(1'b0, 1'b0);

`ifdef NUMBER_SEQ_RESEED_EN
    // lfsr free-runs in IDLE: three idle cycles then start gives slot0 = 008
    do_reset();
    idle(3);
    do_start();
    run_fill(-1, 'h008, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
